// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants, stride decode and output-width formula for the conv datapath
package cnn_pkg;

  localparam int BRAM_ADDR_BIT_DEF = 32;
  localparam int DATA_W_DEF        = 32;

  localparam logic [2:0] STRIDE_1 = 3'd1;
  localparam logic [2:0] STRIDE_2 = 3'd2;
  localparam logic [2:0] STRIDE_4 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic stride_legal(input logic [2:0] stride);
    return (stride == STRIDE_1) || (stride == STRIDE_2) || (stride == STRIDE_4);
  endfunction

  function automatic logic [1:0] stride_log2(input logic [2:0] stride);
    case (stride)
      STRIDE_2: return 2'd1;
      STRIDE_4: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

  // Output map side length for a 3x3 window; callers guarantee width >= 3.
  function automatic logic [11:0] calc_ow(input logic [11:0] width, input logic [2:0] stride);
    return ((width - 12'd3) >> stride_log2(stride)) + 12'd1;
  endfunction

endpackage

// File: rtl/out_rmw_pipe.sv
// rtl/out_rmw_pipe.sv - two-stage read/accumulate/write pipeline with optional clamp and end-flag alignment
module out_rmw_pipe #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_acc,
  input  logic              in_relu,
  input  logic              in_ch_end,
  input  logic              in_img_end,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              ch_end,
  output logic              img_end,
  output logic              pending
);

  logic              s1_valid, s1_acc, s1_relu, s1_ch_end, s1_img_end;
  logic [DATA_W-1:0] s1_data;
  logic              s2_valid, s2_acc, s2_relu, s2_ch_end, s2_img_end;
  logic [ADDR_W-1:0] s2_addr;
  logic [DATA_W-1:0] s2_data;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] result;

  assign pending = s1_valid | s2_valid;

  always_comb begin
    sum    = s2_acc ? (rd_data + s2_data) : s2_data;
    result = (s2_relu && sum[DATA_W-1]) ? '0 : sum;
  end

  // rd_addr doubles as the stage-1 address so the write lands where the read came from.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid   <= 1'b0;
      s1_acc     <= 1'b0;
      s1_relu    <= 1'b0;
      s1_ch_end  <= 1'b0;
      s1_img_end <= 1'b0;
      s1_data    <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      s2_valid   <= 1'b0;
      s2_acc     <= 1'b0;
      s2_relu    <= 1'b0;
      s2_ch_end  <= 1'b0;
      s2_img_end <= 1'b0;
      s2_addr    <= '0;
      s2_data    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      ch_end     <= 1'b0;
      img_end    <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      rd_en    <= in_valid & in_acc;
      if (in_valid) begin
        rd_addr    <= in_addr;
        s1_data    <= in_data;
        s1_acc     <= in_acc;
        s1_relu    <= in_relu;
        s1_ch_end  <= in_ch_end;
        s1_img_end <= in_img_end;
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_addr    <= rd_addr;
        s2_data    <= s1_data;
        s2_acc     <= s1_acc;
        s2_relu    <= s1_relu;
        s2_ch_end  <= s1_ch_end;
        s2_img_end <= s1_img_end;
      end

      wr_en   <= s2_valid;
      ch_end  <= s2_valid & s2_ch_end;
      img_end <= s2_valid & s2_img_end;
      if (s2_valid) begin
        wr_addr <= s2_addr;
        wr_data <= result;
      end
    end
  end

endmodule

// File: rtl/out_addr_gen.sv
// rtl/out_addr_gen.sv - output feature-map writer: FSM, counters, hazard throttle, config latch
// Optional clamp of negative last-channel sums: define OUT_ADDR_GEN_RELU_EN.
module out_addr_gen
  import cnn_pkg::*;
#(
  parameter int BRAM_ADDR_BIT = BRAM_ADDR_BIT_DEF,
  parameter int DATA_W        = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [11:0]              width,
  input  logic [11:0]              channel,
  input  logic [2:0]               stride,
  input  logic [BRAM_ADDR_BIT-1:0] base_addr,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [DATA_W-1:0]        res_data,
  output logic                     rd_en,
  output logic [BRAM_ADDR_BIT-1:0] rd_addr,
  input  logic [DATA_W-1:0]        rd_data,
  output logic                     wr_en,
  output logic [BRAM_ADDR_BIT-1:0] wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     channel_end_out,
  output logic                     img_end_out,
  output logic                     busy,
  output logic                     cfg_err
);

  state_t                   state, state_nxt;
  logic [11:0]              channel_r, ch_cnt;
  logic [23:0]              npix_r, pix_cnt;
  logic [BRAM_ADDR_BIT-1:0] base_r;
  logic                     cfg_err_r;
  logic                     pipe_pending;
  logic                     cfg_ok, start_ok, start_bad;
  logic [11:0]              ow_cfg;
  logic                     accept, last_pix, last_ch, small_frame, relu_on;

  assign cfg_ok      = stride_legal(stride) && (width >= 12'd3) && (channel != 12'd0);
  assign start_ok    = start && (state == ST_IDLE) && cfg_ok;
  assign start_bad   = start && (state == ST_IDLE) && !cfg_ok;
  assign ow_cfg      = calc_ow(width, stride);
  assign accept      = res_valid && res_ready;
  assign last_pix    = (pix_cnt == npix_r - 24'd1);
  assign last_ch     = (ch_cnt == channel_r - 12'd1);
  assign small_frame = (npix_r < 24'd3);
  assign cfg_err     = cfg_err_r;

`ifdef OUT_ADDR_GEN_RELU_EN
  assign relu_on = last_ch;
`else
  assign relu_on = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_RUN;
      ST_RUN:   if (accept && last_pix && last_ch) state_nxt = ST_DRAIN;
      ST_DRAIN: if (img_end_out) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Tiny frames revisit an address before its previous write lands, so only one result may be in flight.
  always_comb begin
    res_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_RUN: begin
        res_ready = !(small_frame && pipe_pending);
        busy      = 1'b1;
      end
      ST_DRAIN: busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      channel_r <= '0;
      npix_r    <= '0;
      base_r    <= '0;
      pix_cnt   <= '0;
      ch_cnt    <= '0;
      cfg_err_r <= 1'b0;
    end else begin
      if (start_bad) cfg_err_r <= 1'b1;
      if (start_ok) begin
        cfg_err_r <= 1'b0;
        channel_r <= channel;
        npix_r    <= {12'd0, ow_cfg} * {12'd0, ow_cfg};
        base_r    <= base_addr;
        pix_cnt   <= '0;
        ch_cnt    <= '0;
      end else if (accept) begin
        if (last_pix) begin
          pix_cnt <= '0;
          ch_cnt  <= ch_cnt + 12'd1;
        end else begin
          pix_cnt <= pix_cnt + 24'd1;
        end
      end
    end
  end

  out_rmw_pipe #(
    .ADDR_W (BRAM_ADDR_BIT),
    .DATA_W (DATA_W)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (accept),
    .in_addr    (base_r + BRAM_ADDR_BIT'(pix_cnt)),
    .in_data    (res_data),
    .in_acc     (ch_cnt != 12'd0),
    .in_relu    (relu_on),
    .in_ch_end  (last_pix),
    .in_img_end (last_pix && last_ch),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ch_end     (channel_end_out),
    .img_end    (img_end_out),
    .pending    (pipe_pending)
  );

endmodule

// File: tb/tb_out_addr_gen.sv
// tb/tb_out_addr_gen.sv - self-checking bench for out_addr_gen with BRAM model and write/read scoreboard
module tb_out_addr_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] width = '0;
  logic [11:0] channel = '0;
  logic [2:0]  stride = '0;
  logic [31:0] base_addr = '0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [31:0] res_data = '0;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data = '0;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        channel_end_out, img_end_out, busy, cfg_err;

  always #5 clk = ~clk;

  out_addr_gen dut (
    .clk(clk), .rst(rst), .start(start), .width(width), .channel(channel),
    .stride(stride), .base_addr(base_addr), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .channel_end_out(channel_end_out), .img_end_out(img_end_out),
    .busy(busy), .cfg_err(cfg_err)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // BRAM: read-first, one-cycle read latency
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] memrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hDEADBEEF;
  endfunction
  always @(posedge clk) begin
    if (rd_en) rd_data <= memrd(rd_addr);
    if (wr_en) mem[wr_addr] = wr_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int due; logic [31:0] addr; logic [31:0] data; bit ce; bit ie; } wexp_t;
  typedef struct { int due; logic [31:0] addr; } rexp_t;
  wexp_t wq[$];
  rexp_t rq[$];

  int m_npix = 0, m_nch = 0;
  logic [31:0] m_base = '0;
  bit clr = 1'b0;
  int m_acc;
  int shadow [int];
  int cnt_ce, cnt_ie, cnt_rd;
  logic [31:0] ie_addr;
  bit prev_ready, consec;

  // Model: result n goes to pixel n % npix of channel n / npix; every write 2 edges after accept.
  always @(negedge clk) begin
    if (!rst || clr) begin
      wq.delete(); rq.delete(); shadow.delete();
      m_acc = 0; cnt_ce = 0; cnt_ie = 0; cnt_rd = 0; ie_addr = '0;
      prev_ready = 1'b0; consec = 1'b0;
    end else begin
      if (wq.size() > 0 && wq[0].due == cyc) begin
        wexp_t w;
        w = wq.pop_front();
        chk("wr_en", wr_en, 1);
        chk("wr_addr", wr_addr, w.addr);
        chk("wr_data", wr_data, w.data);
        chk("channel_end", channel_end_out, w.ce);
        chk("img_end", img_end_out, w.ie);
      end else begin
        chk("wr_en_idle", wr_en, 0);
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        rexp_t r;
        r = rq.pop_front();
        chk("rd_en", rd_en, 1);
        chk("rd_addr", rd_addr, r.addr);
      end else begin
        chk("rd_en_idle", rd_en, 0);
      end
      if (wr_en && channel_end_out) cnt_ce++;
      if (wr_en && img_end_out) begin cnt_ie++; ie_addr = wr_addr; end
      if (rd_en) cnt_rd++;
      if (res_ready && prev_ready) consec = 1'b1;
      prev_ready = res_ready;
      if (res_valid && res_ready && m_npix > 0) begin
        int k, c, v;
        wexp_t w;
        k = m_acc % m_npix;
        c = m_acc / m_npix;
        v = (c == 0) ? int'(res_data) : shadow[k] + int'(res_data);
`ifdef OUT_ADDR_GEN_RELU_EN
        if (c == m_nch - 1 && v < 0) v = 0;
`endif
        shadow[k] = v;
        w.due = cyc + 3; w.addr = m_base + k; w.data = v;
        w.ce = (k == m_npix - 1); w.ie = (k == m_npix - 1) && (c == m_nch - 1);
        wq.push_back(w);
        if (c > 0) rq.push_back('{cyc + 1, m_base + k});
        m_acc++;
      end
    end
  end

  task automatic do_start(input int w, input int s, input int ch, input logic [31:0] b);
    int ow;
    clr = 1'b1;
    @(negedge clk); #1;
    clr = 1'b0;
    width = w[11:0]; stride = s[2:0]; channel = ch[11:0]; base_addr = b;
    m_base = b; m_nch = ch;
    if ((s == 1 || s == 2 || s == 4) && w >= 3 && ch > 0) begin
      ow = (w - 3) / s + 1;
      m_npix = ow * ow;
    end else begin
      m_npix = 0;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int v);
    int n;
    res_valid = 1'b1;
    res_data = v;
    n = 0;
    forever begin
      @(negedge clk);
      if (res_ready) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("busy_drop", busy, 0);
    @(negedge clk);
    chk("all_writes_seen", wq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_res_ready", res_ready, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_ch_end", channel_end_out, 0);
    chk("rst_img_end", img_end_out, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // single channel, raw writes, back-to-back
    do_start(5, 1, 1, 32'h100);
    chk("t1_busy_rise", busy, 1);
    chk("t1_model_npix", m_npix, 9);
    for (int i = 1; i <= 9; i++) send(i);
    wait_idle();
    for (int i = 0; i < 9; i++) chk("t1_mem", memrd(32'h100 + i), i + 1);
    chk("t1_no_reads", cnt_rd, 0);
    chk("t1_img_end_cnt", cnt_ie, 1);
    chk("t1_img_end_addr", ie_addr, 32'h108);

    // illegal configs
    do_start(5, 3, 1, 32'h600);
    repeat (3) begin @(negedge clk); chk("t4a_busy", busy, 0); end
    chk("t4a_cfg_err", cfg_err, 1);
    do_start(2, 1, 1, 32'h600);
    repeat (3) begin @(negedge clk); chk("t4b_busy", busy, 0); end
    chk("t4b_cfg_err", cfg_err, 1);
    do_start(5, 1, 0, 32'h600);
    repeat (3) begin @(negedge clk); chk("t4c_busy", busy, 0); end
    chk("t4c_cfg_err", cfg_err, 1);
    chk("t4_no_mem", mem.exists(32'h600), 0);

    // three channels, stride 2, accumulate
    do_start(7, 2, 3, 32'h200);
    chk("t2_cfg_err_clear", cfg_err, 0);
    chk("t2_model_npix", m_npix, 9);
    for (int i = 0; i < 27; i++) send(2);
    wait_idle();
    for (int i = 0; i < 9; i++) chk("t2_mem", memrd(32'h200 + i), 6);
    chk("t2_ch_end_cnt", cnt_ce, 3);
    chk("t2_img_end_cnt", cnt_ie, 1);
    chk("t2_reads", cnt_rd, 18);

    // npix=1 throttle
    do_start(3, 1, 4, 32'h300);
    chk("t3_model_npix", m_npix, 1);
    for (int i = 0; i < 4; i++) send(5);
    wait_idle();
    chk("t3_no_consec_ready", consec, 0);
    chk("t3_mem", memrd(32'h300), 20);
    chk("t3_ch_end_cnt", cnt_ce, 4);

    // negative sums on the last channel
    do_start(8, 4, 2, 32'h700);
    chk("t5_model_npix", m_npix, 4);
    for (int i = 0; i < 4; i++) send(-7);
    for (int i = 0; i < 4; i++) send(3);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
`ifdef OUT_ADDR_GEN_RELU_EN
      chk("t5_mem_relu", memrd(32'h700 + i), 32'h0);
`else
      chk("t5_mem", memrd(32'h700 + i), 32'hFFFFFFFC);
`endif
    end

    // reset mid-frame, then a fresh frame at the same base
    do_start(5, 1, 2, 32'h400);
    for (int i = 0; i < 12; i++) send(10 + i);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_wr_en", wr_en, 0);
    chk("t6_rd_en", rd_en, 0);
    chk("t6_res_ready", res_ready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ch_end", channel_end_out, 0);
    chk("t6_img_end", img_end_out, 0);
    chk("t6_wr_addr", wr_addr, 0);
    chk("t6_wr_data", wr_data, 0);
    chk("t6_rd_addr", rd_addr, 0);
    @(negedge clk); #1;
    rst = 1'b1;
    do_start(5, 1, 1, 32'h400);
    for (int i = 0; i < 9; i++) send(100 + i);
    wait_idle();
    chk("t6_mem_first", memrd(32'h400), 100);
    chk("t6_mem_last", memrd(32'h408), 108);
    chk("t6_no_reads", cnt_rd, 0);
    chk("t6_img_end_addr", ie_addr, 32'h408);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/out_addr_gen.md
# out_addr_gen

Output-side writer for the convolution datapath; the write-end counterpart of the input window address generator. Accepts one convolution result per output pixel per input channel and writes it to the output feature-map BRAM. The first input channel writes the raw result. Every later channel performs read-modify-write accumulation of the partial sum at the same address, so the BRAM holds the finished output when `img_end_out` pulses.

## Interface
- `BRAM_ADDR_BIT`, 32, output BRAM address width
- `DATA_W`, 32, signed result/partial-sum width
- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle pulse; latches config and begins a frame (ignored while `busy`)
- `width` in 12: input feature-map width/height (square)
- `channel` in 12: number of input channels to accumulate
- `stride` in 3: window stride; legal values 1, 2, 4
- `base_addr` in BRAM_ADDR_BIT: output map base address
- `res_valid` in 1, `res_ready` out 1, `res_data` in DATA_W: result stream (valid/ready)
- `rd_en` out 1, `rd_addr` out BRAM_ADDR_BIT, `rd_data` in DATA_W: BRAM read port, 1-cycle read latency
- `wr_en` out 1, `wr_addr` out BRAM_ADDR_BIT, `wr_data` out DATA_W: BRAM write port
- `channel_end_out` out 1: pulses with the write of the last pixel of each channel
- `img_end_out` out 1: pulses with the write of the last pixel of the last channel
- `busy` out 1: frame in progress
- `cfg_err` out 1: sticky; last `start` had an illegal config

## Operation
- FSM: IDLE -> RUN on `start` with legal config; RUN -> DRAIN after the last result is accepted; DRAIN -> IDLE when the final write issues.
- Illegal config (`stride` not in {1,2,4}, `width`<3, `channel`==0): `cfg_err`=1, stay IDLE. A legal `start` clears `cfg_err`.
- `ow` = ((width-3) >> log2(stride)) + 1, computed at `start`. `npix` = ow*ow, 24 bits.
- Counters: `pix_cnt` runs 0..npix-1 and wraps; `ch_cnt` runs 0..channel-1 and increments on each `pix_cnt` wrap.
- Address = `base_addr` + `pix_cnt`. Addition is modulo 2^BRAM_ADDR_BIT.
- `ch_cnt`==0: `wr_data` = `res_data`, and `rd_en` stays low.
- `ch_cnt`>0: `wr_data` = `rd_data` + `res_data`, two's-complement wrap in DATA_W.
- `res_ready` = (state==RUN) and no hazard stall.
- Hazard: when `npix` < 3, a revisit of the same address would read before the previous write lands. In that case `res_ready` stays low while any result is in the pipeline, so only one result is in flight.
- Reset mid-frame: all counters and the pipeline clear immediately. In-flight writes are dropped.

## Timing
- Reset values: `res_ready`, `rd_en`, `wr_en`, `channel_end_out`, `img_end_out`, `busy`, `cfg_err` are 0. `rd_addr`, `wr_addr`, `wr_data` are 0.
- Accept at edge E0, meaning `res_valid`&`res_ready` is sampled high at E0.
- `rd_en`/`rd_addr` are registered at E0 and seen by the BRAM at E1. `rd_data` is valid after E1.
- `wr_en`/`wr_addr`/`wr_data` are registered at E2. Accept-to-write latency is 2 cycles for every channel.
- Full throughput is 1 result/cycle when `npix` >= 3.
- `channel_end_out`/`img_end_out` are registered at E2 together with the matching `wr_en`, each high for exactly 1 cycle.
- `busy` rises the cycle after `start` and falls the cycle after the final `wr_en`.
- `res_ready` is low in the cycle following the last accepted result.

## Configuration
- `OUT_ADDR_GEN_RELU_EN` defined: on the last channel (`ch_cnt`==channel-1), `wr_data` is clamped to 0 if the sum is negative.
- `OUT_ADDR_GEN_RELU_EN` undefined: the sum is written unmodified.
- All other channels are unaffected in both builds.

## Structure
- Shared package/header `cnn_pkg`:
  - `BRAM_ADDR_BIT` and `DATA_W` defaults
  - stride encoding constants
  - log2-stride decode function
  - the `ow` formula, shared with the input address generator
- Sub-module `out_rmw_pipe`: 2-stage read/accumulate/write pipeline, optional ReLU, end-flag alignment.
- The top level keeps the FSM, counters, hazard throttle and config latching.

## Test plan
- width=5, stride=1, channel=1, base=0x100, results 1..9 back-to-back:
  - writes 0x100..0x108 with data 1..9
  - no `rd_en`
  - `img_end_out` with the 0x108 write
- width=7, stride=2, channel=3, every result = 2:
  - ow=3
  - channel 1+ issues reads
  - final contents all 6
  - `channel_end_out` pulses 3 times, `img_end_out` once
- width=3, stride=1, channel=4, results 5 each:
  - npix=1, throttled: `res_ready` never high on consecutive cycles
  - final value at base = 20
- stride=3 or width=2 or channel=0 on `start`: `cfg_err`=1, `busy` stays 0, no writes.
- width=8, stride=4, channel=2, ch0 results -7, ch1 results 3:
  - with `OUT_ADDR_GEN_RELU_EN` the final writes are 0
  - without it the final writes are -4
- `rst` asserted mid-frame, then a new `start`:
  - outputs go to reset values immediately
  - the next frame starts at `pix_cnt`=0, `ch_cnt`=0 with raw (non-accumulated) writes
